// File: rtl/ifq_types.sv
// Shared types for the instruction-fetch prefetch unit: FSM states,
// queue entry layout and the word-alignment mask applied to redirect targets.
package ifq_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DISCARD
    } ifq_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } ifq_entry_t;

    localparam rv32i_word IFQ_ALIGN_MASK = 32'hFFFFFFFC;

endpackage

// File: rtl/ifq_fifo.sv
// Fetch queue: DEPTH-entry circular buffer of {pc,instr} pairs with flush.
// Pointers wrap naturally because DEPTH is a power of two.
module ifq_fifo
    import ifq_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq,
    input  ifq_entry_t                 enq_data,
    input  logic                       deq,
    output ifq_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    ifq_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_enq;
    logic          do_deq;

    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);
    assign do_enq = enq && (!full || deq);
    assign do_deq = deq && !empty;
    assign head   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update using pre-edge values.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates every read, so stale words are never observed.
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one icache
// request in flight, buffers responses in ifq_fifo and handles redirects.
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to
// the outputs when the queue is empty.
module if_prefetch_unit
    import ifq_types::*;
#(
    parameter int        DEPTH    = 4,
    parameter rv32i_word RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_read,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_rdata,
    input  logic        icache_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    ifq_state_t    state;
    ifq_state_t    state_next;
    rv32i_word     fetch_pc;
    rv32i_word     fetch_pc_next;
    rv32i_word     pend_pc;
    rv32i_word     pend_pc_next;
    rv32i_word     redirect_target;
    ifq_entry_t    head;
    ifq_entry_t    enq_data;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          empty;
    logic          resp_accept;
    logic          bypass_consume;
    logic          enq;
    logic          deq;

    assign redirect_target = redirect_pc & IFQ_ALIGN_MASK;
    assign resp_accept     = !rst && (state == REQ) && icache_resp && !redirect;
`ifdef IFQ_BYPASS_EN
    assign bypass_consume  = resp_accept && empty && deq_ready;
`else
    assign bypass_consume  = 1'b0;
`endif
    assign enq        = resp_accept && !bypass_consume;
    assign deq        = !empty && deq_ready && !redirect;
    assign count_next = count + CW'(enq) - CW'(deq);
    assign enq_data   = '{pc: fetch_pc, instr: icache_rdata};

    // The in-flight address is always fetch_pc; DISCARD leaves it untouched until resp.
    assign icache_read = !rst && (state != HOLD);
    assign icache_addr = fetch_pc;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (deq),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Fetch state, fetch PC and pending redirect target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            pend_pc  <= pend_pc_next;
        end
    end

    // Next-state logic; redirect outranks every other event in every state.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next    = state;
        fetch_pc_next = fetch_pc;
        pend_pc_next  = pend_pc;
        unique case (state)
            REQ: begin
                if (redirect) begin
                    if (icache_resp) begin
                        fetch_pc_next = redirect_target;
                    end else begin
                        pend_pc_next = redirect_target;
                        state_next   = DISCARD;
                    end
                end else if (icache_resp) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    if (count_next == FULL_COUNT) state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_pc_next = redirect_target;
                    state_next    = REQ;
                end else if (!full || deq) begin
                    state_next = REQ;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pend_pc_next = redirect_target;
                    if (icache_resp) begin
                        fetch_pc_next = redirect_target;
                        state_next    = REQ;
                    end
                end else if (icache_resp) begin
                    fetch_pc_next = pend_pc;
                    state_next    = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // Output mux: queue head, or the arriving response when bypassing an empty queue.
    always_comb begin
        out_valid = !empty;
        out_pc    = empty ? '0 : head.pc;
        out_instr = empty ? '0 : head.instr;
`ifdef IFQ_BYPASS_EN
        if (resp_accept && empty) begin
            out_valid = 1'b1;
            out_pc    = fetch_pc;
            out_instr = icache_rdata;
        end
`endif
    end

endmodule
